// File: rtl/uart_tx_if.sv
// uart_tx_if -- request/status bundle between a character sequencer and the
// UART transmitter.
//   send : one-cycle transmit request (sequencer -> transmitter)
//   data : byte to send, sampled together with send
//   busy : frame in progress (transmitter -> sequencer)
//   tx   : serial line, idle high (transmitter -> pin)
interface uart_tx_if;
    logic       send;
    logic [7:0] data;
    logic       busy;
    logic       tx;

    modport master (output send, output data, input busy, input tx);
    modport slave  (input send, input data, output busy, output tx);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter -- 8N1 byte serialiser.
// A send strobe while idle latches data and starts a frame: start bit, eight
// data bits LSB first, one stop bit, each CLOCKS_PER_BIT clocks long.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_tx_if.slave (send/data in, busy/tx out, both outputs registered)
module uart_transmitter #(
    parameter int CLOCKS_PER_BIT = 868
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int CNT_W = ($clog2(CLOCKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLOCKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             bit_done;

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    // Last clock of the current bit slot.
    assign bit_done = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        // The slot counter free-runs through every non-idle state.
        if (state_q != S_IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.send) begin
                    state_d = S_START;
                    shift_d = bus.data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                        idx_d   = '0;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // tx is already high; it simply stays high into idle.
                if (bit_done) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    uart_tx_if if4 ();
    uart_tx_if if1 ();

    uart_transmitter #(.CLOCKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    uart_transmitter #(.CLOCKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame on the 4-clock transmitter; observed 50 clocks from acceptance.
    // poke_ff pulses send with 8'hFF in the middle of the frame.
    task automatic run_frame4(input logic [7:0] d, input bit poke_ff, input string tag);
        logic [9:0] frame;
        int         busy_cnt;
        frame    = '0;
        busy_cnt = 0;
        @(negedge clk);
        if4.send = 1'b1;
        if4.data = d;
        @(posedge clk);
        #1;
        if4.send = 1'b0;
        if4.data = ~d;                      // must not affect the frame in flight
        check({tag, "_busy_e0"}, 32'(if4.busy), 32'd1);
        check({tag, "_tx_e0"}, 32'(if4.tx), 32'd0);
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke_ff && cyc == 13) begin
                if4.send = 1'b1;
                if4.data = 8'hFF;
            end
            if (poke_ff && cyc == 14) if4.send = 1'b0;
            if (if4.busy) busy_cnt++;
            if ((cyc % 4) == 2 && cyc < 40) frame[cyc / 4] = if4.tx;
            if (cyc == 39) check({tag, "_busy_last"}, 32'(if4.busy), 32'd1);
            if (cyc == 40) check({tag, "_busy_fall"}, 32'(if4.busy), 32'd0);
        end
        check({tag, "_frame"}, 32'(frame), 32'({1'b1, d, 1'b0}));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd40);
        check({tag, "_tx_idle"}, 32'(if4.tx), 32'd1);
        check({tag, "_no_refire"}, 32'(if4.busy), 32'd0);
        $display("[TB] %s: sent 0x%02h, decoded 0x%02h, busy %0d cycles", tag, d, frame[8:1], busy_cnt);
    endtask

    initial begin
        string       msg;
        logic [7:0]  vals [4];
        logic [9:0]  bits;
        int          bad, fi, start_t, bcnt, off;
        bit          started;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        if4.send = 1'b0;
        if4.data = '0;
        if1.send = 1'b0;
        if1.data = '0;

        // Asynchronous reset between clock edges.
        #23;
        rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(if4.tx), 32'd1);
        check("rst_async_busy", 32'(if4.busy), 32'd0);
        check("rst_async_tx1", 32'(if1.tx), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (if4.tx !== 1'b1 || if4.busy !== 1'b0) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);
        $display("[TB] idle: 50 cycles observed, %0d bad", bad);

        // Single frame, 'H'; slot pattern 0,0,0,0,1,0,0,1,0,1.
        run_frame4(8'h48, 1'b0, "frame_H");
        check("frame_H_hand", 32'({1'b1, 8'h48, 1'b0}), 32'h290);

        // Hello-world style sequencing.
        msg = "Hello, World!";
        for (int i = 0; i < msg.len(); i++) begin
            run_frame4(msg[i], 1'b0, $sformatf("hello%0d", i));
        end

        // Send while busy is ignored.
        run_frame4(8'h00, 1'b1, "ignore");

        // Reset during data bit 3 of an all-zero byte.
        @(negedge clk);
        if4.send = 1'b1;
        if4.data = 8'h00;
        @(posedge clk);
        #1;
        if4.send = 1'b0;
        repeat (17) @(posedge clk);
        #3;
        check("midrst_pre_busy", 32'(if4.busy), 32'd1);
        check("midrst_pre_tx", 32'(if4.tx), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(if4.tx), 32'd1);
        check("midrst_busy", 32'(if4.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] mid-frame reset applied");
        run_frame4(8'hA5, 1'b0, "after_rst");

        // CLOCKS_PER_BIT=1 with send held high: frames every 11 cycles.
        vals    = '{8'h5A, 8'h01, 8'h80, 8'hC3};
        fi      = 0;
        start_t = 0;
        bcnt    = 0;
        bits    = '0;
        started = 1'b0;
        @(negedge clk);
        if1.data = vals[0];
        if1.send = 1'b1;
        for (int cyc = 0; cyc < 100 && fi < 4; cyc++) begin
            @(posedge clk);
            #1;
            if (started) begin
                off = cyc - start_t;
                if (off <= 9) begin
                    bits[off] = if1.tx;
                    if (if1.busy) bcnt++;
                end else if (off == 10) begin
                    check($sformatf("b2b%0d_busy_low", fi), 32'(if1.busy), 32'd0);
                    check($sformatf("b2b%0d_frame", fi), 32'(bits), 32'({1'b1, vals[fi], 1'b0}));
                    check($sformatf("b2b%0d_busy_cycles", fi), 32'(bcnt), 32'd10);
                    $display("[TB] b2b frame %0d: sent 0x%02h, decoded 0x%02h", fi, vals[fi], bits[8:1]);
                    fi++;
                    started = 1'b0;
                    if (fi == 4) if1.send = 1'b0;
                end
            end
            if (if1.busy && !started && fi < 4) begin
                if (fi > 0) check($sformatf("b2b%0d_gap", fi), 32'(cyc - start_t), 32'd11);
                start_t  = cyc;
                started  = 1'b1;
                bcnt     = 1;
                bits     = '0;
                bits[0]  = if1.tx;
                if (fi < 3) if1.data = vals[fi + 1];
            end
        end
        check("b2b_frames", 32'(fi), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
